min_receive_fsm: RTL and testbench
==================================

# min_receive_fsm

Byte-level MIN frame decoder, the receive counterpart of the board's MIN transmit framer. It consumes bytes from the UART receiver and finds the header. It removes stuffing bytes, checks length and Fletcher-16 checksum, and presents a validated ID plus payload with a single-cycle strobe. Host commands over RS-232 enter the design through this block.

## Interface
- N_DATA_BYTE, 4: maximum payload bytes accepted; sets o_data width.
- i_clk  in  1  system clock (sclk domain).
- i_rst  in  1  asynchronous, active-low reset.
- i_en  in  1  byte strobe: i_data is valid this cycle (one cycle per received byte).
- i_data  in  8  received byte.
- o_valid  out  1  one-cycle pulse: a good frame was decoded.
- o_err  out  1  one-cycle pulse: frame aborted (checksum, length, stuffing or EOF error).
- o_id  out  8  ID byte of the last good frame.
- o_len  out  8  payload length of the last good frame.
- o_data  out  8*N_DATA_BYTE  payload of the last good frame. First byte is in the MSBs, unused low bytes are zero.

## Operation
- Frame on the wire: AA AA AA, ID, LEN, LEN payload bytes, CK_HI, CK_LO, 55.
- Stuffing applies to the body (ID through CK_LO). After two consecutive AA body bytes, the transmitter inserts 55, which is discarded here and not checksummed. The consecutive-AA counter clears after the stuff byte.
- Checksum is Fletcher-16 over unstuffed ID, LEN and payload.
  - s1 and s2 start at 0 and stay in 0..254.
  - Per byte: s1 = (s1 + b) mod 255, then s2 = (s2 + s1) mod 255.
  - CK_HI = s2, CK_LO = s1.
- States:
  - SOF: counts consecutive AA. Any non-AA byte resets the count. The third AA goes to ID.
  - ID: store the ID, go to LEN.
  - LEN: if LEN > N_DATA_BYTE, raise o_err and return to SOF. Otherwise go to PAYLOAD, or to CK_HI if LEN = 0.
  - PAYLOAD: shift bytes into a staging register, go to CK_HI after LEN bytes.
  - CK_HI, CK_LO: capture the checksum bytes.
  - EOF: byte 55 with a matching checksum gives o_valid. Anything else gives o_err. Both return to SOF.
- Body byte handling:
  - AA as the third consecutive body byte (where a stuff byte was due) is a header. The frame is aborted silently (no o_err), checksum and staging are cleared, and the FSM goes to ID.
  - Any other non-55 byte in the stuff position gives o_err and a return to SOF.
- o_id, o_len and o_data update only on o_valid. Staging registers are separate, so a failed frame never disturbs the last good outputs.
- When i_en = 0, state and registers hold.

## Timing
- Reset: o_valid = 0, o_err = 0, o_id = 0, o_len = 0, o_data = 0. State is SOF, AA count, checksum and byte counters are 0.
- Reset is asynchronous. Asserting it mid-frame drops the frame with no o_err.
- o_valid and o_err are registered. They pulse in the cycle after the i_en cycle carrying the EOF byte or the offending byte, and are never both high.
- o_id, o_len and o_data change in the same cycle o_valid is high, and are stable until the next o_valid.
- Back-to-back i_en on consecutive cycles must be accepted with no lost bytes. The FSM handles one byte per i_en cycle.

## Test plan
- Good frame AA AA AA 01 04 12 34 56 78 24 1A 55 -> one o_valid pulse, o_id = 01, o_len = 04, o_data = 12345678, o_err never high.
- Stuffed frame: ID 01, LEN 2, payload AA AA, sent as AA AA AA 01 02 AA AA 55 <ck> 55 with a model-computed checksum -> o_valid, o_data = AAAA0000, o_len = 02.
- Bad checksum: the first frame with CK_LO = 1B -> o_err pulse, no o_valid, outputs keep their previous values.
- Length overflow: LEN = 05 with N_DATA_BYTE = 4 -> o_err one cycle after the LEN byte, FSM back in SOF. A following good frame decodes correctly.
- Resync: a frame cut after two payload bytes, followed directly by AA AA AA and a full good frame -> exactly one o_valid for the second frame, no o_err.
- Reset mid-payload, release, then send the good frame -> no pulses during reset, single o_valid afterwards. Outputs are 0 until that o_valid.

Source files
------------

// File: rtl/min_receive_fsm.sv
`default_nettype none
// min_receive_fsm: MIN frame decoder. It finds the header, removes stuffing and checks length and Fletcher-16.
// It presents the ID, LEN and payload of each good frame with a one-cycle o_valid.
module min_receive_fsm #(
  parameter int N_DATA_BYTE = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [7:0]               i_data,
  output logic                     o_valid,
  output logic                     o_err,
  output logic [7:0]               o_id,
  output logic [7:0]               o_len,
  output logic [8*N_DATA_BYTE-1:0] o_data
);
  localparam logic [7:0] SOF_BYTE   = 8'hAA;
  localparam logic [7:0] STUFF_BYTE = 8'h55;
  localparam logic [7:0] MAX_LEN    = 8'(N_DATA_BYTE);
  localparam int         DW         = 8 * N_DATA_BYTE;

  typedef enum logic [2:0] {
    ST_SOF     = 3'd0,
    ST_ID      = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CK_HI   = 3'd4,
    ST_CK_LO   = 3'd5,
    ST_EOF     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    aa_cnt_q, aa_cnt_d;
  logic [7:0]    s1_q, s1_d, s2_q, s2_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    id_q, id_d, len_q, len_d;
  logic [7:0]    ck_hi_q, ck_hi_d, ck_lo_q, ck_lo_d;
  logic [DW-1:0] stage_q, stage_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [7:0]    out_id_q, out_id_d, out_len_q, out_len_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [7:0]    s1_next, s2_next;
  logic          stuff_slot;

  function automatic logic [7:0] add_mod255(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 9'd255) sum = sum - 9'd255;
    return sum[7:0];
  endfunction

  assign s1_next    = add_mod255(s1_q, i_data);
  assign s2_next    = add_mod255(s2_q, s1_next);
  // Two AA body bytes in a row mean this byte must be the stuff byte.
  assign stuff_slot = (state_q != ST_SOF) && (aa_cnt_q == 2'd2);

  always_comb begin
    state_d    = state_q;
    aa_cnt_d   = aa_cnt_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    len_d      = len_q;
    ck_hi_d    = ck_hi_q;
    ck_lo_d    = ck_lo_q;
    stage_d    = stage_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    out_id_d   = out_id_q;
    out_len_d  = out_len_q;
    out_data_d = out_data_q;

    if (i_en) begin
      if (stuff_slot) begin
        aa_cnt_d = 2'd0;
        if (i_data == SOF_BYTE) begin
          // A third AA is a fresh header: drop the current frame without an error.
          state_d = ST_ID;
          s1_d    = 8'd0;
          s2_d    = 8'd0;
          cnt_d   = 8'd0;
          stage_d = '0;
        end else if (i_data != STUFF_BYTE) begin
          err_d   = 1'b1;
          state_d = ST_SOF;
        end
      end else begin
        if (state_q != ST_SOF) aa_cnt_d = (i_data == SOF_BYTE) ? aa_cnt_q + 2'd1 : 2'd0;
        case (state_q)
          ST_SOF: begin
            if (i_data != SOF_BYTE) begin
              aa_cnt_d = 2'd0;
            end else if (aa_cnt_q == 2'd2) begin
              aa_cnt_d = 2'd0;
              state_d  = ST_ID;
              s1_d     = 8'd0;
              s2_d     = 8'd0;
              cnt_d    = 8'd0;
              stage_d  = '0;
            end else begin
              aa_cnt_d = aa_cnt_q + 2'd1;
            end
          end
          ST_ID: begin
            id_d    = i_data;
            s1_d    = s1_next;
            s2_d    = s2_next;
            state_d = ST_LEN;
          end
          ST_LEN: begin
            if (i_data > MAX_LEN) begin
              err_d    = 1'b1;
              aa_cnt_d = 2'd0;
              state_d  = ST_SOF;
            end else begin
              len_d   = i_data;
              s1_d    = s1_next;
              s2_d    = s2_next;
              cnt_d   = 8'd0;
              state_d = (i_data == 8'd0) ? ST_CK_HI : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            for (int i = 0; i < N_DATA_BYTE; i++) begin
              if (cnt_q == 8'(i)) stage_d[DW-8-8*i +: 8] = i_data;
            end
            s1_d  = s1_next;
            s2_d  = s2_next;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == len_q) state_d = ST_CK_HI;
          end
          ST_CK_HI: begin
            ck_hi_d = i_data;
            state_d = ST_CK_LO;
          end
          ST_CK_LO: begin
            ck_lo_d = i_data;
            state_d = ST_EOF;
          end
          ST_EOF: begin
            aa_cnt_d = 2'd0;
            state_d  = ST_SOF;
            if ((i_data == STUFF_BYTE) && (ck_hi_q == s2_q) && (ck_lo_q == s1_q)) begin
              valid_d    = 1'b1;
              out_id_d   = id_q;
              out_len_d  = len_q;
              out_data_d = stage_q;
            end else begin
              err_d = 1'b1;
            end
          end
          default: begin
            aa_cnt_d = 2'd0;
            state_d  = ST_SOF;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_SOF;
      aa_cnt_q   <= 2'd0;
      s1_q       <= 8'd0;
      s2_q       <= 8'd0;
      cnt_q      <= 8'd0;
      id_q       <= 8'd0;
      len_q      <= 8'd0;
      ck_hi_q    <= 8'd0;
      ck_lo_q    <= 8'd0;
      stage_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      out_id_q   <= 8'd0;
      out_len_q  <= 8'd0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      aa_cnt_q   <= aa_cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      len_q      <= len_d;
      ck_hi_q    <= ck_hi_d;
      ck_lo_q    <= ck_lo_d;
      stage_q    <= stage_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      out_id_q   <= out_id_d;
      out_len_q  <= out_len_d;
      out_data_q <= out_data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_id    = out_id_q;
  assign o_len   = out_len_q;
  assign o_data  = out_data_q;
endmodule
`default_nettype wire

// File: tb/tb_min_receive_fsm.sv
`default_nettype none
// tb_min_receive_fsm: directed MIN frames. A scoreboard queue holds the expected good frames.
module tb_min_receive_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        o_valid, o_err;
  logic [7:0]  o_id, o_len;
  logic [31:0] o_data;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  len;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   exp_err = 0;
  int   exp_valid = 0;
  int   gap_cycles = 0;

  logic [7:0] pl_good [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] pl_aa   [4] = '{8'hAA, 8'hAA, 8'h00, 8'h00};
  logic [7:0] pl_none [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  min_receive_fsm #(.N_DATA_BYTE(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_en   (en),
    .i_data (din),
    .o_valid(o_valid),
    .o_err  (o_err),
    .o_id   (o_id),
    .o_len  (o_len),
    .o_data (o_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("pulse_in_reset", {62'd0, o_valid, o_err}, 64'd0);
    end else begin
      if (o_valid || o_err) check("valid_and_err", {63'd0, o_valid & o_err}, 64'd0);
      if (o_err) n_err++;
      if (o_valid) begin
        n_valid++;
        check("valid_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("sb_id", {56'd0, o_id}, {56'd0, mon_e.id});
          check("sb_len", {56'd0, o_len}, {56'd0, mon_e.len});
          check("sb_data", {32'd0, o_data}, {32'd0, mon_e.data});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    en  = 1'b1;
    din = b;
    @(negedge clk);
    en  = 1'b0;
    if (gap_cycles > 0) repeat (gap_cycles) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] fletcher(input logic [7:0] id, input logic [7:0] len,
                                           input logic [7:0] pl [4]);
    int s1, s2;
    s1 = (0 + id) % 255;   s2 = s1 % 255;
    s1 = (s1 + len) % 255; s2 = (s2 + s1) % 255;
    for (int i = 0; i < 4; i++) begin
      if (i < len) begin
        s1 = (s1 + pl[i]) % 255;
        s2 = (s2 + s1) % 255;
      end
    end
    return {s2[7:0], s1[7:0]};
  endfunction

  task automatic send_body(input logic [7:0] b, inout int aa);
    send_byte(b);
    if (b == 8'hAA) begin
      aa++;
      if (aa == 2) begin
        send_byte(8'h55);
        aa = 0;
      end
    end else begin
      aa = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] len, input logic [7:0] pl [4],
                            input logic [7:0] ck_lo_xor);
    logic [15:0] ck;
    int          aa;
    exp_t        e;
    bit          good;
    ck   = fletcher(id, len, pl);
    good = (ck_lo_xor == 8'h00);
    if (good) begin
      e.id   = id;
      e.len  = len;
      e.data = 32'd0;
      for (int i = 0; i < 4; i++) if (i < len) e.data[31-8*i -: 8] = pl[i];
      exp_q.push_back(e);
      exp_valid++;
    end else begin
      exp_err++;
    end
    aa = 0;
    repeat (3) send_byte(8'hAA);
    send_body(id, aa);
    send_body(len, aa);
    for (int i = 0; i < 4; i++) if (i < len) send_body(pl[i], aa);
    send_body(ck[15:8], aa);
    send_body(ck[7:0] ^ ck_lo_xor, aa);
    gap_cycles = 0;
    send_byte(8'h55);
    check("eof_valid", {63'd0, o_valid}, {63'd0, good});
    check("eof_err", {63'd0, o_err}, {63'd0, !good});
  endtask

  initial begin
    idle(3);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_err", {63'd0, o_err}, 64'd0);
    check("rst_id", {56'd0, o_id}, 64'd0);
    check("rst_len", {56'd0, o_len}, 64'd0);
    check("rst_data", {32'd0, o_data}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Reference frame, then a stuffed payload AA AA.
    send_frame(8'h01, 8'd4, pl_good, 8'h00);
    idle(3);
    check("good_data_hold", {32'd0, o_data}, 64'h12345678);
    send_frame(8'h01, 8'd2, pl_aa, 8'h00);
    idle(3);

    // Checksum error keeps the last good outputs.
    send_frame(8'h01, 8'd4, pl_good, 8'h01);
    idle(3);
    check("badck_id", {56'd0, o_id}, 64'h01);
    check("badck_len", {56'd0, o_len}, 64'h02);
    check("badck_data", {32'd0, o_data}, 64'hAAAA0000);

    // Length overflow: error one cycle after the LEN byte.
    repeat (3) send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h05);
    check("len_ovf_err", {63'd0, o_err}, 64'd1);
    exp_err++;
    idle(2);
    send_frame(8'h01, 8'd4, pl_good, 8'h00);
    idle(3);

    // Zero-length frame with idle cycles between bytes.
    gap_cycles = 2;
    send_frame(8'h7E, 8'd0, pl_none, 8'h00);
    idle(3);

    // Truncated frame followed directly by a full header and frame.
    repeat (3) send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'h12);
    send_byte(8'h34);
    send_frame(8'h01, 8'd4, pl_good, 8'h00);
    idle(3);
    check("resync_err_cnt", 64'(n_err), 64'(exp_err));

    // Asynchronous reset mid-payload.
    repeat (3) send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'h12);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_id", {56'd0, o_id}, 64'd0);
    check("midrst_len", {56'd0, o_len}, 64'd0);
    check("midrst_data", {32'd0, o_data}, 64'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check("postrst_data", {32'd0, o_data}, 64'd0);
    send_frame(8'h01, 8'd4, pl_good, 8'h00);
    idle(4);

    check("final_valid_cnt", 64'(n_valid), 64'(exp_valid));
    check("final_err_cnt", 64'(n_err), 64'(exp_err));
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
